// File: rtl/enemy_sprite_renderer.sv
// Enemy sprite renderer: erases the box at its last drawn position, then draws it at the
// newly latched position and colour, one pixel per clock, clipped to the visible screen.
module enemy_sprite_renderer #(
    parameter int unsigned SIZE      = 10,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       drawEn,
    input  logic [7:0] enemyX,
    input  logic [6:0] enemyY,
    input  logic [2:0] colourIn,
    output logic [7:0] vgaX,
    output logic [6:0] vgaY,
    output logic [2:0] vgaColour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LastIdx = CW'(SIZE - 1);

    typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [7:0]    new_x_q, new_x_d, prev_x_q, prev_x_d;
    logic [6:0]    new_y_q, new_y_d, prev_y_q, prev_y_d;
    logic [2:0]    new_col_q, new_col_d;
    logic          new_draw_en_q, new_draw_en_d;
    logic          prev_valid_q, prev_valid_d;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       active, in_bounds;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cx_q          <= '0;
            cy_q          <= '0;
            new_x_q       <= '0;
            new_y_q       <= '0;
            new_col_q     <= '0;
            new_draw_en_q <= 1'b0;
            prev_x_q      <= '0;
            prev_y_q      <= '0;
            prev_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            new_x_q       <= new_x_d;
            new_y_q       <= new_y_d;
            new_col_q     <= new_col_d;
            new_draw_en_q <= new_draw_en_d;
            prev_x_q      <= prev_x_d;
            prev_y_q      <= prev_y_d;
            prev_valid_q  <= prev_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        new_x_d       = new_x_q;
        new_y_d       = new_y_q;
        new_col_d     = new_col_q;
        new_draw_en_d = new_draw_en_q;
        prev_x_d      = prev_x_q;
        prev_y_d      = prev_y_q;
        prev_valid_d  = prev_valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    new_x_d       = enemyX;
                    new_y_d       = enemyY;
                    new_col_d     = colourIn;
                    new_draw_en_d = drawEn;
                    cx_d          = '0;
                    cy_d          = '0;
                    if (prev_valid_q) state_d = StErase;
                    else if (drawEn)  state_d = StDraw;
                    else              state_d = StDone;
                end
            end
            StErase, StDraw: begin
                // x scans fastest; every pixel takes a cycle even when clipped
                if (cx_q == LastIdx) begin
                    cx_d = '0;
                    if (cy_q == LastIdx) begin
                        cy_d    = '0;
                        state_d = (state_q == StErase && new_draw_en_q) ? StDraw : StDone;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            StDone: begin
                if (new_draw_en_q) begin
                    prev_x_d     = new_x_q;
                    prev_y_d     = new_y_q;
                    prev_valid_d = 1'b1;
                end else begin
                    prev_valid_d = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        active    = (state_q == StErase) || (state_q == StDraw);
        base_x    = (state_q == StErase) ? prev_x_q : new_x_q;
        base_y    = (state_q == StErase) ? prev_y_q : new_y_q;
        sum_x     = {1'b0, base_x} + 9'(cx_q);
        sum_y     = {1'b0, base_y} + 8'(cy_q);
        in_bounds = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
        vgaX      = active ? sum_x[7:0] : '0;
        vgaY      = active ? sum_y[6:0] : '0;
        vgaColour = (state_q == StDraw) ? new_col_q : BG_COLOUR;
        plot      = active && in_bounds;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
    end

endmodule

// File: tb/tb_enemy_sprite_renderer.sv
// Bench for enemy_sprite_renderer: directed table, busy/abort sequences and random requests
// checked cycle by cycle against a pixel-list model of erase and draw passes.
module tb_enemy_sprite_renderer;

    localparam int SIZE = 10;

    logic       clk = 1'b0;
    logic       reset, start, drawEn;
    logic [7:0] enemyX;
    logic [6:0] enemyY;
    logic [2:0] colourIn;
    logic [7:0] vgaX;
    logic [6:0] vgaY;
    logic [2:0] vgaColour;
    logic       plot, busy, done;

    enemy_sprite_renderer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .drawEn    (drawEn),
        .enemyX    (enemyX),
        .enemyY    (enemyY),
        .colourIn  (colourIn),
        .vgaX      (vgaX),
        .vgaY      (vgaY),
        .vgaColour (vgaColour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
    } px_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       de;
        int         plots;
        int         len;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // model of what the screen holds
    logic       m_valid;
    logic [7:0] m_px;
    logic [6:0] m_py;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add_box(inout px_t q[$], input logic [7:0] bx, input logic [6:0] by,
                           input logic [2:0] col);
        int sx, sy;
        px_t e;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                sx    = int'(bx) + c;
                sy    = int'(by) + r;
                e.plot = (sx < 160) && (sy < 120);
                e.x   = sx[7:0];
                e.y   = sy[6:0];
                e.col = col;
                q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'({plot, busy, done, vgaX, vgaY, vgaColour}), 32'd0);
        reset   = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic run_req(input logic [7:0] x, input logic [6:0] y, input logic [2:0] col,
                           input logic de, input bit inject, input int abort_at,
                           output int n_plot, output int n_len);
        px_t q[$];
        if (m_valid) add_box(q, m_px, m_py, 3'b000);
        if (de) add_box(q, x, y, col);
        n_len  = q.size();
        n_plot = 0;
        @(posedge clk);
        #1;
        start = 1'b1; drawEn = de; enemyX = x; enemyY = y; colourIn = col;
        @(posedge clk);
        #1;
        start    = 1'b0;
        enemyX   = 8'($urandom);
        enemyY   = 7'($urandom);
        colourIn = 3'($urandom);
        drawEn   = 1'($urandom);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            n_plot += int'(plot);
            check("pixel", 32'({plot, busy, done, vgaX, vgaY, vgaColour}),
                  32'({q[k].plot, 1'b1, 1'b0, q[k].x, q[k].y, q[k].col}));
            if (inject && (k + 1 == 5 || k + 1 == 50)) begin
                start  = 1'b1;
                enemyX = 8'd90;
            end else begin
                start = 1'b0;
            end
            if (abort_at == k + 1) begin
                reset = 1'b1;
                @(negedge clk);
                check("abort", 32'({plot, busy, done}), 32'd0);
                reset   = 1'b0;
                m_valid = 1'b0;
                n_len   = k + 1;
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done", 32'({plot, busy, done}), 32'b011);
        @(negedge clk);
        check("idle", 32'({plot, busy, done}), 32'b000);
        if (de) begin
            m_valid = 1'b1;
            m_px    = x;
            m_py    = y;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    vec_t tbl[7];
    int   np, nl;

    initial begin
        tbl[0] = '{x: 8'd20,  y: 7'd30,  col: 3'b100, de: 1'b1, plots: 100, len: 100};
        tbl[1] = '{x: 8'd20,  y: 7'd34,  col: 3'b010, de: 1'b1, plots: 200, len: 200};
        tbl[2] = '{x: 8'd20,  y: 7'd30,  col: 3'b010, de: 1'b1, plots: 200, len: 200};
        tbl[3] = '{x: 8'd0,   y: 7'd0,   col: 3'b111, de: 1'b0, plots: 100, len: 100};
        tbl[4] = '{x: 8'd155, y: 7'd115, col: 3'b111, de: 1'b1, plots: 25,  len: 100};
        tbl[5] = '{x: 8'd250, y: 7'd125, col: 3'b001, de: 1'b1, plots: 25,  len: 200};
        tbl[6] = '{x: 8'd0,   y: 7'd0,   col: 3'b101, de: 1'b1, plots: 100, len: 200};

        reset = 1'b1; start = 1'b0; drawEn = 1'b0;
        enemyX = '0; enemyY = '0; colourIn = '0;
        m_valid = 1'b0; m_px = '0; m_py = '0;

        do_reset();
        foreach (tbl[i]) begin
            run_req(tbl[i].x, tbl[i].y, tbl[i].col, tbl[i].de, 1'b0, 0, np, nl);
            check($sformatf("vec%0d_plots", i), 32'(np), 32'(tbl[i].plots));
            check($sformatf("vec%0d_len", i), 32'(nl), 32'(tbl[i].len));
        end

        // starts while busy must be dropped
        do_reset();
        run_req(8'd40, 7'd0, 3'b011, 1'b1, 1'b1, 0, np, nl);
        check("busy_start_plots", 32'(np), 32'd100);

        // reset mid-draw, then no erase pass on the next request
        run_req(8'd20, 7'd30, 3'b100, 1'b1, 1'b0, 50, np, nl);
        run_req(8'd60, 7'd60, 3'b001, 1'b1, 1'b0, 0, np, nl);
        check("post_abort_len", 32'(nl), 32'd100);

        for (int i = 0; i < 15; i++) begin
            run_req(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), 3'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'b0, 0, np, nl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
